// File: rtl/sc_regbank_wr_arbiter.sv
// Round-robin arbiter for the single write port of the register bank.
// Registers the winning write, drives a one-cycle load strobe, and rejects writes to fixed registers.
module sc_regbank_wr_arbiter #(
  parameter int unsigned                   DATAWIDTH_BUS = 32,
  parameter int unsigned                   ADDRWIDTH     = 4,
  parameter int unsigned                   NUM_REQ       = 4,
  parameter logic [(2**ADDRWIDTH)-1:0]     PROTECT_MASK  = 16'h0001
) (
  input  logic                             SC_RegBankArb_CLOCK_50,
  input  logic                             SC_RegBankArb_Reset_InHigh,
  input  logic                             SC_RegBankArb_Halt_InHigh,
  input  logic [NUM_REQ-1:0]               SC_RegBankArb_Req_In,
  input  logic [NUM_REQ*ADDRWIDTH-1:0]     SC_RegBankArb_Addr_In,
  input  logic [NUM_REQ*DATAWIDTH_BUS-1:0] SC_RegBankArb_Data_In,
  output logic [NUM_REQ-1:0]               SC_RegBankArb_Ack_Out,
  output logic [NUM_REQ-1:0]               SC_RegBankArb_Err_Out,
  output logic [(2**ADDRWIDTH)-1:0]        SC_RegBankArb_Load_Out,
  output logic [DATAWIDTH_BUS-1:0]         SC_RegBankArb_DataBUS_Out,
  output logic                             SC_RegBankArb_Busy_Out,
  output logic [15:0]                      SC_RegBankArb_WrCount_Out
);

  localparam int unsigned NumRegs = 2**ADDRWIDTH;
  localparam int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {StIdle, StWrite} state_e;

  state_e                   r_state;
  logic [IdxW-1:0]          r_ptr;
  logic [NUM_REQ-1:0]       r_ack;
  logic [NUM_REQ-1:0]       r_err;
  logic [NumRegs-1:0]       r_load;
  logic [DATAWIDTH_BUS-1:0] r_data_bus;
  logic                     r_busy;
  logic [15:0]              r_wr_count;

  logic [ADDRWIDTH-1:0]     w_addr_arr [NUM_REQ];
  logic [DATAWIDTH_BUS-1:0] w_data_arr [NUM_REQ];
  logic                     w_found;
  logic [IdxW-1:0]          w_winner;
  logic [ADDRWIDTH-1:0]     w_win_addr;
  logic [DATAWIDTH_BUS-1:0] w_win_data;
  logic                     w_protected;
  logic [NumRegs-1:0]       w_load_onehot;
  logic [NUM_REQ-1:0]       w_req_onehot;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      w_addr_arr[k] = SC_RegBankArb_Addr_In[k*ADDRWIDTH +: ADDRWIDTH];
      w_data_arr[k] = SC_RegBankArb_Data_In[k*DATAWIDTH_BUS +: DATAWIDTH_BUS];
    end
  end

  // Scan ptr+1 .. ptr+NUM_REQ so the last winner has lowest priority.
  always_comb begin
    int unsigned     v_idx;
    logic [IdxW-1:0] v_cand;
    w_found  = 1'b0;
    w_winner = '0;
    v_idx    = 0;
    v_cand   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      v_idx  = (32'(r_ptr) + i) % NUM_REQ;
      v_cand = IdxW'(v_idx);
      if (!w_found && SC_RegBankArb_Req_In[v_cand]) begin
        w_found  = 1'b1;
        w_winner = v_cand;
      end
    end
  end

  assign w_win_addr    = w_addr_arr[w_winner];
  assign w_win_data    = w_data_arr[w_winner];
  assign w_protected   = PROTECT_MASK[w_win_addr];
  assign w_load_onehot = NumRegs'(1) << w_win_addr;
  assign w_req_onehot  = NUM_REQ'(1) << w_winner;

  // Strobes are loaded on the IDLE->WRITE edge so they are visible for exactly the WRITE cycle.
  always_ff @(posedge SC_RegBankArb_CLOCK_50) begin
    if (SC_RegBankArb_Reset_InHigh) begin
      r_state    <= StIdle;
      r_ptr      <= IdxW'(NUM_REQ - 1);
      r_ack      <= '0;
      r_err      <= '0;
      r_load     <= '0;
      r_data_bus <= '0;
      r_busy     <= 1'b0;
      r_wr_count <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (!SC_RegBankArb_Halt_InHigh && w_found) begin
            r_state    <= StWrite;
            r_busy     <= 1'b1;
            r_data_bus <= w_win_data;
            r_ptr      <= w_winner;
            if (w_protected) begin
              r_err  <= w_req_onehot;
              r_load <= '0;
            end else begin
              r_ack      <= w_req_onehot;
              r_load     <= w_load_onehot;
              r_wr_count <= r_wr_count + 16'd1;
            end
          end
        end
        StWrite: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_ack   <= '0;
          r_err   <= '0;
          r_load  <= '0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign SC_RegBankArb_Ack_Out     = r_ack;
  assign SC_RegBankArb_Err_Out     = r_err;
  assign SC_RegBankArb_Load_Out    = r_load;
  assign SC_RegBankArb_DataBUS_Out = r_data_bus;
  assign SC_RegBankArb_Busy_Out    = r_busy;
  assign SC_RegBankArb_WrCount_Out = r_wr_count;

  a_load_onehot0: assert property (@(posedge SC_RegBankArb_CLOCK_50) $onehot0(r_load));
  a_ack_err_excl: assert property (@(posedge SC_RegBankArb_CLOCK_50) (r_ack & r_err) == '0);
  a_ack_onehot0:  assert property (@(posedge SC_RegBankArb_CLOCK_50) $onehot0(r_ack | r_err));

endmodule

// File: tb/tb_sc_regbank_wr_arbiter.sv
// Scoreboard bench for sc_regbank_wr_arbiter: stimulus pushes expected writes, a monitor checks pulses.
module tb_sc_regbank_wr_arbiter;

  typedef struct packed {
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [15:0] load;
    logic [31:0] data;
    logic [15:0] wc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         halt = 1'b0;
  logic [3:0]   req = '0;
  logic [15:0]  addr_bus = '0;
  logic [127:0] data_bus = '0;
  logic [3:0]   ack;
  logic [3:0]   err;
  logic [15:0]  load;
  logic [31:0]  dbus;
  logic         busy;
  logic [15:0]  wc;

  int   checks = 0;
  int   errors = 0;
  int   iters;
  exp_t exp_q[$];

  sc_regbank_wr_arbiter dut (
    .SC_RegBankArb_CLOCK_50     (clk),
    .SC_RegBankArb_Reset_InHigh (rst),
    .SC_RegBankArb_Halt_InHigh  (halt),
    .SC_RegBankArb_Req_In       (req),
    .SC_RegBankArb_Addr_In      (addr_bus),
    .SC_RegBankArb_Data_In      (data_bus),
    .SC_RegBankArb_Ack_Out      (ack),
    .SC_RegBankArb_Err_Out      (err),
    .SC_RegBankArb_Load_Out     (load),
    .SC_RegBankArb_DataBUS_Out  (dbus),
    .SC_RegBankArb_Busy_Out     (busy),
    .SC_RegBankArb_WrCount_Out  (wc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, expv);
    end
  endtask

  task automatic set_src(input int k, input logic [3:0] a, input logic [31:0] d);
    addr_bus[k*4 +: 4]   = a;
    data_bus[k*32 +: 32] = d;
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] e, input logic [15:0] l,
                      input logic [31:0] d, input logic [15:0] w);
    exp_t x;
    x.ack = a; x.err = e; x.load = l; x.data = d; x.wc = w;
    exp_q.push_back(x);
  endtask

  // Requesters drop their request once they see their own Ack or Err.
  task automatic drain(input int budget, output int n);
    n = 0;
    while (req != 0 && n < budget) begin
      @(negedge clk);
      n++;
      req = req & ~(ack | err);
    end
    checks++;
    if (req != 0) begin
      errors++;
      $display("FAIL drain_timeout req=%b after %0d cycles", req, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (ack != 0 || err != 0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse ack=%b err=%b load=%h", ack, err, load);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (ack !== e.ack || err !== e.err || load !== e.load || dbus !== e.data ||
            wc !== e.wc || busy !== 1'b1) begin
          errors++;
          $display("FAIL write got ack=%b err=%b load=%h data=%h wc=%h busy=%b expected ack=%b err=%b load=%h data=%h wc=%h busy=1",
                   ack, err, load, dbus, wc, busy, e.ack, e.err, e.load, e.data, e.wc);
        end
      end
    end else if (load != 0) begin
      checks++;
      errors++;
      $display("FAIL stray_load got %h expected 0000", load);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ack", 32'(ack), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_load", 32'(load), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_dbus", dbus, 32'h0);
    check("reset_wc", 32'(wc), 32'h0);

    // Single write
    set_src(0, 4'd3, 32'hDEADBEEF);
    req = 4'b0001;
    push(4'b0001, 4'b0000, 16'h0008, 32'hDEADBEEF, 16'd1);
    drain(20, iters);
    check("t1_latency", 32'(iters), 32'd1);
    @(negedge clk);
    check("t1_idle_busy", 32'(busy), 32'h0);
    check("t1_idle_dbus_hold", dbus, 32'hDEADBEEF);

    // All four requesting: rotation 0,1,2,3, one write per 2 cycles
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_src(k, 4'(4 + k), 32'hA0A0_0000 + 32'(k));
      push(4'(1 << k), 4'b0000, 16'(16'h0010 << k), 32'hA0A0_0000 + 32'(k), 16'(k + 1));
    end
    req = 4'b1111;
    drain(40, iters);
    check("t2_cycles", 32'(iters), 32'd7);

    // Protected register, then ptr=2 so requester 3 beats 0
    set_src(2, 4'd0, 32'h0BAD_0002);
    req = 4'b0100;
    push(4'b0000, 4'b0100, 16'h0000, 32'h0BAD_0002, 16'd4);
    drain(20, iters);
    set_src(3, 4'd9, 32'h3333_3333);
    set_src(0, 4'd10, 32'h4444_4444);
    req = 4'b1001;
    push(4'b1000, 4'b0000, 16'h0200, 32'h3333_3333, 16'd5);
    push(4'b0001, 4'b0000, 16'h0400, 32'h4444_4444, 16'd6);
    drain(20, iters);

    // Halt holds off the grant
    halt = 1'b1;
    set_src(1, 4'd2, 32'h5555_5555);
    req = 4'b0010;
    repeat (5) @(negedge clk);
    check("t4_halt_busy", 32'(busy), 32'h0);
    check("t4_halt_wc", 32'(wc), 32'd6);
    halt = 1'b0;
    push(4'b0010, 4'b0000, 16'h0004, 32'h5555_5555, 16'd7);
    drain(20, iters);
    check("t4_release_latency", 32'(iters), 32'd1);

    // Reset during WRITE
    @(negedge clk);
    set_src(0, 4'd5, 32'h6666_6666);
    req = 4'b0001;
    push(4'b0001, 4'b0000, 16'h0020, 32'h6666_6666, 16'd8);
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("t5_rst_load", 32'(load), 32'h0);
    check("t5_rst_ack", 32'(ack), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_wc", 32'(wc), 32'h0);
    rst = 1'b0;
    set_src(0, 4'd11, 32'h7777_7777);
    set_src(1, 4'd12, 32'h8888_8888);
    req = 4'b0011;
    push(4'b0001, 4'b0000, 16'h0800, 32'h7777_7777, 16'd1);
    push(4'b0010, 4'b0000, 16'h1000, 32'h8888_8888, 16'd2);
    drain(20, iters);

    // WrCount wrap
    @(negedge clk);
    force dut.r_wr_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_wr_count;
    check("t6_preload", 32'(wc), 32'h0000_FFFF);
    set_src(0, 4'd13, 32'h9999_9999);
    req = 4'b0001;
    push(4'b0001, 4'b0000, 16'h2000, 32'h9999_9999, 16'd0);
    drain(20, iters);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
